// File: rtl/clint_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : clint_ctrl
// Description: Core-local interrupt/exception sequencer. Accepts ECALL/EBREAK,
//              level external interrupts and MRET, writes mepc/mstatus/mcause
//              through a CSR write port and issues a one-cycle pc redirect.
// Revision   : 1.0 - initial release
// ============================================================================
module clint_ctrl #(
    parameter int                   CPU_WIDTH  = 32,
    parameter int                   INT_WIDTH  = 8,
    parameter logic [CPU_WIDTH-1:0] MCAUSE_EXT = CPU_WIDTH'(32'h8000_000B)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INT_WIDTH-1:0] int_flag_i,
    input  logic [CPU_WIDTH-1:0] inst_i,
    input  logic [CPU_WIDTH-1:0] inst_addr_i,
    input  logic                 jump_flag_i,
    input  logic [CPU_WIDTH-1:0] jump_addr_i,
    input  logic                 alu_busy_i,
    input  logic                 jtag_halt_i,
    input  logic [CPU_WIDTH-1:0] csr_mstatus_i,
    input  logic [CPU_WIDTH-1:0] csr_mepc_i,
    input  logic [CPU_WIDTH-1:0] csr_mtvec_i,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [CPU_WIDTH-1:0] csr_wdata_o,
    output logic                 hold_flag_o,
    output logic [CPU_WIDTH-1:0] int_addr_o,
    output logic                 int_assert_o
);

    localparam logic [CPU_WIDTH-1:0] c_inst_ecall  = CPU_WIDTH'(32'h0000_0073);
    localparam logic [CPU_WIDTH-1:0] c_inst_ebreak = CPU_WIDTH'(32'h0010_0073);
    localparam logic [CPU_WIDTH-1:0] c_inst_mret   = CPU_WIDTH'(32'h3020_0073);
    localparam logic [CPU_WIDTH-1:0] c_cause_ecall = CPU_WIDTH'(11);
    localparam logic [CPU_WIDTH-1:0] c_cause_ebrk  = CPU_WIDTH'(3);
    localparam logic [11:0]          c_csr_mstatus = 12'h300;
    localparam logic [11:0]          c_csr_mepc    = 12'h341;
    localparam logic [11:0]          c_csr_mcause  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_W_MRET    = 3'd4,
        S_ASSERT    = 3'd5
    } state_t;

    state_t               r_state;
    logic [CPU_WIDTH-1:0] r_cause;
    logic [CPU_WIDTH-1:0] r_mstatus_snap;
    logic                 r_is_mret;
    logic [CPU_WIDTH-1:0] r_int_addr_hold;

    logic                 w_is_ecall;
    logic                 w_sync;
    logic                 w_async;
    logic                 w_mret;
    logic                 w_accept;
    logic [CPU_WIDTH-1:0] w_trap_mepc;
    logic [CPU_WIDTH-1:0] w_trap_mstatus;
    logic [CPU_WIDTH-1:0] w_mret_mstatus;
    logic [CPU_WIDTH-1:0] w_redirect;

    always_comb begin
        w_is_ecall  = (inst_i == c_inst_ecall);
        w_sync      = w_is_ecall || (inst_i == c_inst_ebreak);
        w_async     = (|int_flag_i) && csr_mstatus_i[3] && !alu_busy_i;
        w_mret      = (inst_i == c_inst_mret);
        // Reset gating keeps hold low while the core is held in reset
        w_accept    = !rst && (r_state == S_IDLE) && !jtag_halt_i &&
                      (w_sync || w_async || w_mret);
        w_trap_mepc = (!w_sync && jump_flag_i) ? jump_addr_i : inst_addr_i;

        w_trap_mstatus    = r_mstatus_snap;
        w_trap_mstatus[7] = r_mstatus_snap[3];
        w_trap_mstatus[3] = 1'b0;

        w_mret_mstatus    = csr_mstatus_i;
        w_mret_mstatus[3] = csr_mstatus_i[7];
        w_mret_mstatus[7] = 1'b1;

        w_redirect  = r_is_mret ? csr_mepc_i : csr_mtvec_i;
    end

    assign hold_flag_o = (r_state != S_IDLE) || w_accept;
    assign int_addr_o  = (r_state == S_ASSERT) ? w_redirect : r_int_addr_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cause         <= '0;
            r_mstatus_snap  <= '0;
            r_is_mret       <= 1'b0;
            r_int_addr_hold <= '0;
            csr_we_o        <= 1'b0;
            csr_waddr_o     <= '0;
            csr_wdata_o     <= '0;
            int_assert_o    <= 1'b0;
        end else begin
            csr_we_o     <= 1'b0;
            csr_waddr_o  <= '0;
            csr_wdata_o  <= '0;
            int_assert_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        csr_we_o <= 1'b1;
                        if (w_sync || w_async) begin
                            r_state        <= S_W_MEPC;
                            r_is_mret      <= 1'b0;
                            r_mstatus_snap <= csr_mstatus_i;
                            r_cause        <= w_sync ? (w_is_ecall ? c_cause_ecall : c_cause_ebrk)
                                                     : MCAUSE_EXT;
                            csr_waddr_o    <= c_csr_mepc;
                            csr_wdata_o    <= w_trap_mepc;
                        end else begin
                            r_state     <= S_W_MRET;
                            r_is_mret   <= 1'b1;
                            csr_waddr_o <= c_csr_mstatus;
                            csr_wdata_o <= w_mret_mstatus;
                        end
                    end
                end
                S_W_MEPC: begin
                    r_state     <= S_W_MSTATUS;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= c_csr_mstatus;
                    csr_wdata_o <= w_trap_mstatus;
                end
                S_W_MSTATUS: begin
                    r_state     <= S_W_MCAUSE;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= c_csr_mcause;
                    csr_wdata_o <= r_cause;
                end
                S_W_MCAUSE, S_W_MRET: begin
                    r_state      <= S_ASSERT;
                    int_assert_o <= 1'b1;
                end
                S_ASSERT: begin
                    r_state         <= S_IDLE;
                    r_int_addr_hold <= w_redirect;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_clint_ctrl
// Description: Randomized bench for clint_ctrl against a scheduled-event model
//              that also keeps the mstatus/mepc/mtvec CSR state.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_clint_ctrl;

    localparam logic [31:0] c_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_mret   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, alu_busy_i, jtag_halt_i;
    logic [31:0] csr_mstatus_i, csr_mepc_i, csr_mtvec_i;
    logic        csr_we_o, hold_flag_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    clint_ctrl #(.CPU_WIDTH(32), .INT_WIDTH(8), .MCAUSE_EXT(32'h8000_000B)) u_dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .alu_busy_i(alu_busy_i), .jtag_halt_i(jtag_halt_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_mepc_i(csr_mepc_i), .csr_mtvec_i(csr_mtvec_i), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .hold_flag_o(hold_flag_o),
        .int_addr_o(int_addr_o), .int_assert_o(int_assert_o)
    );

    always #5 clk = ~clk;

    // One entry per future non-idle cycle of an accepted sequence
    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        is_assert;
        logic        is_mret;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_mstatus, m_mepc, m_mtvec, m_last_addr;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                                input logic as, input logic mr);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.is_assert = as; e.is_mret = mr;
        return e;
    endfunction

    task automatic run_cycle(input bit do_rst);
        int          r;
        logic [31:0] tmp;
        logic        special, busy_seq, trig_sync, trig_async, trig_mret;
        logic [31:0] cause, epc, st;
        exp_t        e;
        @(negedge clk);
        if (q.size() == 0) begin
            if ($urandom_range(0, 19) == 0) m_mstatus = $urandom;
            if ($urandom_range(0, 19) == 0) m_mtvec   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 29) == 0) m_mepc    = $urandom & 32'hFFFF_FFFC;
        end
        r = $urandom_range(0, 99);
        tmp = $urandom;
        if (r < 12)      inst_i = c_ecall;
        else if (r < 22) inst_i = c_ebreak;
        else if (r < 34) inst_i = c_mret;
        else             inst_i = {tmp[31:7], 7'h13};
        special     = (r < 34);
        r = $urandom_range(0, 5);
        int_flag_i  = (r == 0) ? 8'($urandom) : (r < 3) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        alu_busy_i  = !special && ($urandom_range(0, 4) == 0);
        jtag_halt_i = ($urandom_range(0, 9) == 0);
        jump_flag_i = $urandom_range(0, 1);
        jump_addr_i = $urandom & 32'hFFFF_FFFC;
        inst_addr_i = $urandom & 32'hFFFF_FFFC;
        csr_mstatus_i = m_mstatus;
        csr_mepc_i    = m_mepc;
        csr_mtvec_i   = m_mtvec;
        rst = do_rst;
        #1;
        if (do_rst) begin
            q.delete();
            m_last_addr = 32'h0;
            check("rst_hold", {31'b0, hold_flag_o}, 32'h0);
            check("rst_we", {31'b0, csr_we_o}, 32'h0);
            check("rst_assert", {31'b0, int_assert_o}, 32'h0);
            check("rst_int_addr", int_addr_o, 32'h0);
            return;
        end
        busy_seq = (q.size() != 0);
        e = busy_seq ? q.pop_front() : mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
        trig_sync  = !busy_seq && !jtag_halt_i && (inst_i == c_ecall || inst_i == c_ebreak);
        trig_async = !busy_seq && !jtag_halt_i && !trig_sync &&
                     (int_flag_i != 0) && m_mstatus[3] && !alu_busy_i;
        trig_mret  = !busy_seq && !jtag_halt_i && !trig_sync && !trig_async && (inst_i == c_mret);

        check("hold", {31'b0, hold_flag_o}, {31'b0, busy_seq || trig_sync || trig_async || trig_mret});
        check("we", {31'b0, csr_we_o}, {31'b0, e.we});
        if (e.we) begin
            check("waddr", {20'b0, csr_waddr_o}, {20'b0, e.addr});
            check("wdata", csr_wdata_o, e.data);
        end
        check("assert", {31'b0, int_assert_o}, {31'b0, e.is_assert});
        if (e.is_assert) m_last_addr = e.is_mret ? m_mepc : m_mtvec;
        check("int_addr", int_addr_o, m_last_addr);

        if (e.we && e.addr == 12'h300) m_mstatus = e.data;
        if (e.we && e.addr == 12'h341) m_mepc    = e.data;

        if (trig_sync || trig_async) begin
            cause = trig_sync ? ((inst_i == c_ecall) ? 32'd11 : 32'd3) : 32'h8000_000B;
            epc   = (trig_async && jump_flag_i) ? jump_addr_i : inst_addr_i;
            st    = m_mstatus & ~32'h88;
            if (m_mstatus[3]) st = st | 32'h80;
            q.push_back(mk(1'b1, 12'h341, epc, 1'b0, 1'b0));
            q.push_back(mk(1'b1, 12'h300, st, 1'b0, 1'b0));
            q.push_back(mk(1'b1, 12'h342, cause, 1'b0, 1'b0));
            q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b0));
        end else if (trig_mret) begin
            st = (m_mstatus & ~32'h08) | 32'h80;
            if (m_mstatus[7]) st = st | 32'h08;
            q.push_back(mk(1'b1, 12'h300, st, 1'b0, 1'b0));
            q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b1));
        end
    endtask

    initial begin
        rst = 1'b1;
        int_flag_i = '0; inst_i = '0; inst_addr_i = '0; jump_flag_i = 1'b0;
        jump_addr_i = '0; alu_busy_i = 1'b0; jtag_halt_i = 1'b0;
        m_mstatus = 32'h0000_0008; m_mepc = 32'h0000_0104; m_mtvec = 32'h0000_0200;
        m_last_addr = '0;
        csr_mstatus_i = m_mstatus; csr_mepc_i = m_mepc; csr_mtvec_i = m_mtvec;
        repeat (2) @(posedge clk);
        #1;
        check("reset_we", {31'b0, csr_we_o}, 32'h0);
        check("reset_waddr", {20'b0, csr_waddr_o}, 32'h0);
        check("reset_wdata", csr_wdata_o, 32'h0);
        check("reset_int_addr", int_addr_o, 32'h0);
        check("reset_assert", {31'b0, int_assert_o}, 32'h0);
        check("reset_hold", {31'b0, hold_flag_o}, 32'h0);

        for (int i = 0; i < 5000; i++)
            run_cycle((q.size() != 0) && ($urandom_range(0, 149) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
